// File: rtl/id_ex_pipe_pkg.sv
// Shared widths and the bubble control encoding for the ID/EX pipeline register.
// Used by id_ex_pipe and loaduse_detect.
package id_ex_pipe_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W     = 16;

  // All-zero control bundle: no writeback, no memory access, no side effects.
  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_pipe_loaduse_detect.sv
// Load-use comparator: flags an ID instruction that reads the rd of a load now in EX.
// Purely combinational so it can be reused by a later-stage interlock.
module loaduse_detect
  import id_ex_pipe_pkg::*;
(
  input  logic                  ex_valid,
  input  logic                  ex_mem_rd,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  id_valid,
  input  logic                  id_uses_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  output logic                  load_use
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign rs1_hit  = id_uses_rs1 && (id_rs1_addr == ex_rd);
  assign rs2_hit  = id_uses_rs2 && (id_rs2_addr == ex_rd);
  assign load_use = ex_valid && ex_mem_rd && (ex_rd != '0) && id_valid && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use interlock, branch flush and MEM back-pressure hold.
// Optional macro IDEX_PERF_EN adds saturating load-use and flush event counters.
module id_ex_pipe
  import id_ex_pipe_pkg::XLEN, id_ex_pipe_pkg::REG_ADDR_W;
#(
  parameter int              CTRL_W   = id_ex_pipe_pkg::CTRL_W,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [XLEN-1:0]       id_rs1_val,
  input  logic [XLEN-1:0]       id_rs2_val,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_wb_en,
  input  logic                  id_mem_rd,
  input  logic [CTRL_W-1:0]     id_ctrl,
  input  logic                  flush,
  input  logic                  mem_wait,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_pc,
  output logic [REG_ADDR_W-1:0] ex_rs1_addr,
  output logic [REG_ADDR_W-1:0] ex_rs2_addr,
  output logic [XLEN-1:0]       ex_rs1_val,
  output logic [XLEN-1:0]       ex_rs2_val,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_wb_en,
  output logic                  ex_mem_rd,
  output logic [CTRL_W-1:0]     ex_ctrl,
`ifdef IDEX_PERF_EN
  output logic [31:0]           perf_lu_cnt,
  output logic [31:0]           perf_flush_cnt,
`endif
  output logic                  stall_id
);

  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'(id_ex_pipe_pkg::CTRL_NOP);

  logic load_use;
  logic load_bubble;

  loaduse_detect u_loaduse_detect (
    .ex_valid    (ex_valid),
    .ex_mem_rd   (ex_mem_rd),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_uses_rs1 (id_uses_rs1),
    .id_rs1_addr (id_rs1_addr),
    .id_uses_rs2 (id_uses_rs2),
    .id_rs2_addr (id_rs2_addr),
    .load_use    (load_use)
  );

  // Flush wins over everything; mem_wait freezes EX even when a load-use is pending.
  assign stall_id    = !rst && !flush && (mem_wait || load_use);
  assign load_bubble = rst || flush || (!mem_wait && load_use);

  always_ff @(posedge clk) begin
    if (load_bubble) begin
      ex_valid    <= 1'b0;
      ex_pc       <= RESET_PC;
      ex_rs1_addr <= '0;
      ex_rs2_addr <= '0;
      ex_rs1_val  <= '0;
      ex_rs2_val  <= '0;
      ex_rd       <= '0;
      ex_wb_en    <= 1'b0;
      ex_mem_rd   <= 1'b0;
      ex_ctrl     <= BUBBLE_CTRL;
    end else if (!mem_wait) begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rs1_addr <= id_rs1_addr;
      ex_rs2_addr <= id_rs2_addr;
      ex_rs1_val  <= id_rs1_val;
      ex_rs2_val  <= id_rs2_val;
      ex_rd       <= id_rd;
      ex_wb_en    <= id_valid && id_wb_en;
      ex_mem_rd   <= id_valid && id_mem_rd;
      ex_ctrl     <= id_valid ? id_ctrl : BUBBLE_CTRL;
    end
  end

`ifdef IDEX_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lu_cnt    <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (flush && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
      if (load_use && !flush && !mem_wait && (perf_lu_cnt != 32'hFFFF_FFFF)) begin
        perf_lu_cnt <= perf_lu_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
